// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: decoded control, operands and addresses with stall/flush and a valid bit.
// Build with IDEX_PERF_CNT_EN defined to include the saturating flush/stall counters.
module id_ex_pipe_reg #(
    parameter int XLEN  = 32,
    parameter int RA_W  = 5,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             StallE,
    input  logic             FlushE,
    input  logic             ValidD,
    input  logic             RegWriteD,
    input  logic             MemWriteD,
    input  logic             ALUSrcD,
    input  logic             luiD,
    input  logic [1:0]       ResultSrcD,
    input  logic [1:0]       JumpD,
    input  logic [2:0]       BranchD,
    input  logic [2:0]       ALUControlD,
    input  logic [XLEN-1:0]  RD1D,
    input  logic [XLEN-1:0]  RD2D,
    input  logic [XLEN-1:0]  PCD,
    input  logic [XLEN-1:0]  ImmExtD,
    input  logic [XLEN-1:0]  PCPlus4D,
    input  logic [RA_W-1:0]  Rs1D,
    input  logic [RA_W-1:0]  Rs2D,
    input  logic [RA_W-1:0]  RdD,
    output logic             RegWriteE,
    output logic             MemWriteE,
    output logic             ALUSrcE,
    output logic             luiE,
    output logic [1:0]       ResultSrcE,
    output logic [1:0]       JumpE,
    output logic [2:0]       BranchE,
    output logic [2:0]       ALUControlE,
    output logic [XLEN-1:0]  RD1E,
    output logic [XLEN-1:0]  RD2E,
    output logic [XLEN-1:0]  PCE,
    output logic [XLEN-1:0]  ImmExtE,
    output logic [XLEN-1:0]  PCPlus4E,
    output logic [RA_W-1:0]  Rs1E,
    output logic [RA_W-1:0]  Rs2E,
    output logic [RA_W-1:0]  RdE,
    output logic             ValidE,
    output logic [CNT_W-1:0] FlushCntE,
    output logic [CNT_W-1:0] StallCntE
);

    localparam int CTRL_W = 14;
    localparam int DATA_W = 5 * XLEN + 3 * RA_W;

    logic [CTRL_W-1:0] ctrl_d, ctrl_q;
    logic [DATA_W-1:0] data_d, data_q;
    logic              valid_d, valid_q;

    // An invalid decode still carries its data forward, but its control is squashed to a NOP.
    always_comb begin
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        valid_d = valid_q;
        if (FlushE) begin
            ctrl_d  = '0;
            data_d  = '0;
            valid_d = 1'b0;
        end else if (!StallE) begin
            data_d  = {RD1D, RD2D, PCD, ImmExtD, PCPlus4D, Rs1D, Rs2D, RdD};
            ctrl_d  = ValidD ? {RegWriteD, MemWriteD, ALUSrcD, luiD, ResultSrcD, JumpD,
                                BranchD, ALUControlD} : '0;
            valid_d = ValidD;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign {RegWriteE, MemWriteE, ALUSrcE, luiE, ResultSrcE, JumpE, BranchE, ALUControlE} = ctrl_q;
    assign {RD1E, RD2E, PCE, ImmExtE, PCPlus4E, Rs1E, Rs2E, RdE} = data_q;
    assign ValidE = valid_q;

`ifdef IDEX_PERF_CNT_EN
    logic [CNT_W-1:0] flush_cnt_d, flush_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;

    // A flush that coincides with a stall is counted only as a flush.
    always_comb begin
        flush_cnt_d = flush_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (FlushE && (flush_cnt_q != '1))
            flush_cnt_d = flush_cnt_q + 1'b1;
        if (!FlushE && StallE && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flush_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            flush_cnt_q <= flush_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign FlushCntE = flush_cnt_q;
    assign StallCntE = stall_cnt_q;
`else
    assign FlushCntE = '0;
    assign StallCntE = '0;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Self-checking bench for id_ex_pipe_reg: directed steps plus random traffic against a field-level model.
module tb_id_ex_pipe_reg;

    localparam int CNT_W = 4;
    localparam int MAXC  = (1 << CNT_W) - 1;

    typedef struct packed {
        logic        rw, mw, as, lui;
        logic [1:0]  rs, j;
        logic [2:0]  br, alu;
        logic [31:0] rd1, rd2, pc, imm, pc4;
        logic [4:0]  rs1, rs2, rd;
    } bundle_t;

    logic    clk, rst, StallE, FlushE, ValidD;
    bundle_t din, obs, exp_b;
    logic    exp_v;
    int      exp_fc, exp_sc;
    int      checks, errors;

    logic             RegWriteE, MemWriteE, ALUSrcE, luiE, ValidE;
    logic [1:0]       ResultSrcE, JumpE;
    logic [2:0]       BranchE, ALUControlE;
    logic [31:0]      RD1E, RD2E, PCE, ImmExtE, PCPlus4E;
    logic [4:0]       Rs1E, Rs2E, RdE;
    logic [CNT_W-1:0] FlushCntE, StallCntE;

    id_ex_pipe_reg #(.XLEN(32), .RA_W(5), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .StallE(StallE), .FlushE(FlushE), .ValidD(ValidD),
        .RegWriteD(din.rw), .MemWriteD(din.mw), .ALUSrcD(din.as), .luiD(din.lui),
        .ResultSrcD(din.rs), .JumpD(din.j), .BranchD(din.br), .ALUControlD(din.alu),
        .RD1D(din.rd1), .RD2D(din.rd2), .PCD(din.pc), .ImmExtD(din.imm), .PCPlus4D(din.pc4),
        .Rs1D(din.rs1), .Rs2D(din.rs2), .RdD(din.rd),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ALUSrcE(ALUSrcE), .luiE(luiE),
        .ResultSrcE(ResultSrcE), .JumpE(JumpE), .BranchE(BranchE), .ALUControlE(ALUControlE),
        .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .ImmExtE(ImmExtE), .PCPlus4E(PCPlus4E),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .ValidE(ValidE),
        .FlushCntE(FlushCntE), .StallCntE(StallCntE)
    );

    assign obs = {RegWriteE, MemWriteE, ALUSrcE, luiE, ResultSrcE, JumpE, BranchE, ALUControlE,
                  RD1E, RD2E, PCE, ImmExtE, PCPlus4E, Rs1E, Rs2E, RdE};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bundle_t rand_bundle();
        bundle_t b;
        b.rw  = 1'($urandom);        b.mw  = 1'($urandom);
        b.as  = 1'($urandom);        b.lui = 1'($urandom);
        b.rs  = 2'($urandom);        b.j   = 2'($urandom);
        b.br  = 3'($urandom);        b.alu = 3'($urandom);
        b.rd1 = $urandom;            b.rd2 = $urandom;
        b.pc  = $urandom;            b.imm = $urandom;
        b.pc4 = b.pc + 32'd4;
        b.rs1 = 5'($urandom);        b.rs2 = 5'($urandom);
        b.rd  = 5'($urandom);
        return b;
    endfunction

    function automatic int sat(int v);
        return (v > MAXC) ? MAXC : v;
    endfunction

    task automatic chk(input string tag, input logic [255:0] o, input logic [255:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic check_all(input string tag);
        int fc_e, sc_e;
`ifdef IDEX_PERF_CNT_EN
        fc_e = exp_fc;
        sc_e = exp_sc;
`else
        fc_e = 0;
        sc_e = 0;
`endif
        chk({tag, ".bundle"}, 256'(obs), 256'(exp_b));
        chk({tag, ".valid"}, 256'(ValidE), 256'(exp_v));
        chk({tag, ".flushcnt"}, 256'(FlushCntE), 256'(fc_e));
        chk({tag, ".stallcnt"}, 256'(StallCntE), 256'(sc_e));
    endtask

    task automatic model_reset();
        exp_b  = '0;
        exp_v  = 1'b0;
        exp_fc = 0;
        exp_sc = 0;
    endtask

    // Applies the stage rules to the inputs present at the edge just taken.
    task automatic model_edge();
        if (FlushE) begin
            exp_b  = '0;
            exp_v  = 1'b0;
            exp_fc = sat(exp_fc + 1);
        end else if (StallE) begin
            exp_sc = sat(exp_sc + 1);
        end else begin
            exp_b = din;
            exp_v = ValidD;
            if (!ValidD) begin
                exp_b.rw = 0; exp_b.mw = 0; exp_b.as = 0; exp_b.lui = 0;
                exp_b.rs = 0; exp_b.j  = 0; exp_b.br = 0; exp_b.alu = 0;
            end
        end
    endtask

    task automatic step(input string tag, input bit fl, input bit st, input bit vd);
        FlushE = fl;
        StallE = st;
        ValidD = vd;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    bundle_t a, b;

    initial begin
        checks = 0;
        errors = 0;
        model_reset();

        // Reset held with nonzero inputs
        rst = 1'b0;
        din = '1;
        FlushE = 1'b0; StallE = 1'b0; ValidD = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all("reset_hold");
        @(negedge clk);
        rst = 1'b1;
        step("reset_release_load", 0, 0, 1);

        // Directed normal load
        din = '0;
        din.rw = 1'b1; din.alu = 3'b010; din.rd1 = 32'h0000_1234; din.rd = 5'd5;
        step("normal_load", 0, 0, 1);

        // Stall: A held while D changes to B
        a = rand_bundle();
        b = rand_bundle();
        din = a;
        step("load_a", 0, 0, 1);
        din = b;
        for (int i = 0; i < 3; i++) step("stall_hold", 0, 1, 1);
        step("stall_release", 0, 0, 1);

        // Flush together with stall
        din = rand_bundle();
        din.mw = 1'b1; din.j = 2'b01;
        step("flush_with_stall", 1, 1, 1);

        // Invalid decode keeps data, drops control
        din = rand_bundle();
        din.rw = 1'b1; din.rd2 = 32'hDEAD_BEEF;
        step("invalid_decode", 0, 0, 0);

        // Flush counter saturation
        for (int i = 0; i < 20; i++) step("flush_sat", 1, 0, 1);
        for (int i = 0; i < 20; i++) step("stall_sat", 0, 1, 1);

        // Randomised traffic
        for (int i = 0; i < 300; i++) begin
            din = rand_bundle();
            step("random", ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 4) != 0));
        end

        // Asynchronous reset mid-stall, between edges
        din = rand_bundle();
        step("pre_reset_load", 0, 0, 1);
        StallE = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        check_all("async_reset");
        @(posedge clk);
        #1;
        check_all("async_reset_clocked");
        @(negedge clk);
        rst = 1'b1;
        step("post_reset_stall", 0, 1, 1);
        din = rand_bundle();
        step("post_reset_load", 0, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
- ID/EX pipeline register sitting directly downstream of the decode-stage controller and register file.
- Captures the decoded control bundle plus operand/address data each cycle and presents it to the execute stage.
- Stall and flush come from the hazard unit; a valid bit tracks bubbles.
- Optional saturating counters record flushes and stalls for performance analysis.

Parameters:
XLEN, 32, datapath width (operands, PC, immediate)
RA_W, 5, register-address width
CNT_W, 32, width of each performance counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-low (asserted when 0)
StallE  input  1  hold all stored contents this cycle
FlushE  input  1  load a bubble this cycle
ValidD  input  1  decode stage holds a real instruction
RegWriteD, MemWriteD, ALUSrcD, luiD  input  1 each  decoded control bits
ResultSrcD, JumpD  input  2 each  decoded control fields
BranchD, ALUControlD  input  3 each  decoded control fields
RD1D, RD2D, PCD, ImmExtD, PCPlus4D  input  XLEN each  operands, PC, extended immediate, PC+4
Rs1D, Rs2D, RdD  input  RA_W each  source/destination register addresses
RegWriteE, MemWriteE, ALUSrcE, luiE  output  1 each  registered control bits
ResultSrcE, JumpE  output  2 each  registered control fields
BranchE, ALUControlE  output  3 each  registered control fields
RD1E, RD2E, PCE, ImmExtE, PCPlus4E  output  XLEN each  registered data
Rs1E, Rs2E, RdE  output  RA_W each  registered addresses
ValidE  output  1  execute stage holds a real instruction
FlushCntE  output  CNT_W  number of flush events
StallCntE  output  CNT_W  number of stall cycles

Behaviour:
- rst=0 (asynchronous): every output, including ValidE and both counters, goes to 0 immediately and stays 0 while asserted.
- Latency: 1 cycle. Inputs sampled at posedge clk appear on E outputs after that edge.
- Priority per edge: FlushE > StallE > normal load.
- Flush: all control outputs, data outputs and addresses load 0; ValidE loads 0.
  - The zeroed state is a legal NOP bubble: RegWriteE=0, MemWriteE=0, JumpE=0, BranchE=0.
- Stall (FlushE=0): all outputs hold their previous values, including ValidE.
- Normal load, ValidD=1: all fields load from D inputs; ValidE loads 1.
- Normal load, ValidD=0: data and address fields load from D inputs; control outputs load 0; ValidE loads 0. No architectural side effect is possible.
- FlushE and StallE both 1: treated as flush. StallCntE does not increment; FlushCntE does.
- Counters:
  - FlushCntE increments on every edge with FlushE=1.
  - StallCntE increments on every edge with StallE=1 and FlushE=0.
  - Both saturate at 2^CNT_W-1; neither wraps.
- rst deasserted mid-stall: first edge after release behaves normally from the reset (zero) state.
- No combinational path from any input to any output.

Optional Feature:
- Macro IDEX_PERF_CNT_EN.
- Defined: FlushCntE and StallCntE behave as described above.
- Undefined: counter registers are not built; FlushCntE and StallCntE are constant 0. Port list is unchanged.

Test Plan:
1. Reset: hold rst=0 with all inputs nonzero, toggle clk -> all outputs 0 and ValidE=0; release rst -> next edge loads inputs.
2. Normal load: ValidD=1, RegWriteD=1, ALUControlD=3'b010, RD1D=32'h0000_1234, RdD=5 -> after 1 edge RegWriteE=1, ALUControlE=3'b010, RD1E=32'h0000_1234, RdE=5, ValidE=1.
3. Stall: load instruction A, then StallE=1 for 3 cycles while D inputs change to B -> outputs stay A; StallCntE=3; release -> B appears the next edge.
4. Flush with stall: FlushE=1, StallE=1 with MemWriteD=1, JumpD=2'b01 -> MemWriteE=0, JumpE=0, ValidE=0; FlushCntE=1, StallCntE unchanged.
5. Invalid decode: ValidD=0, RegWriteD=1, RD2D=32'hDEAD_BEEF -> RegWriteE=0, RD2E=32'hDEAD_BEEF, ValidE=0.
6. Saturation (CNT_W=4, macro defined): 20 consecutive FlushE cycles -> FlushCntE=4'hF. With macro undefined -> FlushCntE=0.
